// File: rtl/key_event_scheduler.sv
// key_event_scheduler
//   Turns decoded PS/2 key events into a stream of press events for a
//   two-player game. Each player has four mapped keys. A fresh press sets the
//   player's held bit and is queued in that player's FIFO. A repeat or a
//   release is never queued. A single output register presents one event at
//   a time and is fed from the two FIFOs by round-robin arbitration. Enter
//   produces a one-cycle start pulse.
//
// Ports
//   CLOCK_50               in   system clock, rising edge
//   reset                  in   synchronous, active-high
//   valid                  in   one-cycle strobe qualifying makeBreak/inCode
//   makeBreak              in   1 = make (press), 0 = break (release)
//   inCode[7:0]            in   set-2 scan code, prefixes already stripped
//   ev_ready               in   consumer accepts the presented event
//   ev_valid               out  event presented (FSM in PRESENT)
//   ev_player              out  0 = left, 1 = right
//   ev_key[1:0]            out  key index within the player
//   held_left/right[3:0]   out  held-key bitmaps
//   start_pulse            out  one cycle after an Enter make
//   ovf_left/right         out  sticky queue-overflow flags
//   cnt_left/right         out  FIFO occupancy, output register excluded
module key_event_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     valid,
    input  logic                     makeBreak,
    input  logic [7:0]               inCode,
    input  logic                     ev_ready,
    output logic                     ev_valid,
    output logic                     ev_player,
    output logic [1:0]               ev_key,
    output logic [3:0]               held_left,
    output logic [3:0]               held_right,
    output logic                     start_pulse,
    output logic                     ovf_left,
    output logic                     ovf_right,
    output logic [$clog2(DEPTH):0]   cnt_left,
    output logic [$clog2(DEPTH):0]   cnt_right
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic                   ev_player_q, ev_player_d;
    logic [1:0]             ev_key_q, ev_key_d;
    logic                   last_q, last_d;
    logic                   start_q, start_d;
    logic [1:0]             ovf_q, ovf_d;
    logic [1:0][3:0]        held_q, held_d;
    logic [1:0][CW-1:0]     cnt_q, cnt_d;
    logic [1:0][AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [1:0][AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [1:0]             mem_q [2][DEPTH];
    logic [1:0]             mem_d [2][DEPTH];

    // Scan-code decode
    logic       hit, plr;
    logic [1:0] key;
    always_comb begin
        hit = 1'b1;
        plr = 1'b0;
        key = 2'd0;
        case (inCode)
            8'h16: key = 2'd0;
            8'h1E: key = 2'd1;
            8'h26: key = 2'd2;
            8'h29: key = 2'd3;
            8'h69: begin plr = 1'b1; key = 2'd0; end
            8'h72: begin plr = 1'b1; key = 2'd1; end
            8'h7A: begin plr = 1'b1; key = 2'd2; end
            8'h59: begin plr = 1'b1; key = 2'd3; end
            default: hit = 1'b0;
        endcase
    end

    logic       accept, can_load, load, gnt, make_new;
    logic [1:0] nonempty, pop, push, ovf_set;

    always_comb begin
        accept   = (state_q == PRESENT) && ev_ready;
        can_load = (state_q == IDLE) || accept;
        for (int p = 0; p < 2; p++) nonempty[p] = (cnt_q[p] != '0);
        // Tie goes to the player not granted last; otherwise the only
        // non-empty queue wins.
        gnt  = (&nonempty) ? ~last_q : nonempty[1];
        load = can_load && (|nonempty);
        pop  = '0;
        if (load) pop[gnt] = 1'b1;

        // A press is queued only on the held 0->1 transition. A full queue
        // still accepts the push when it is being popped on the same edge.
        make_new = valid && makeBreak && hit && !held_q[plr][key];
        push     = '0;
        ovf_set  = '0;
        if (make_new) begin
            if (cnt_q[plr] != CW'(DEPTH) || pop[plr]) push[plr]    = 1'b1;
            else                                      ovf_set[plr] = 1'b1;
        end

        held_d = held_q;
        if (valid && hit) held_d[plr][key] = makeBreak;

        mem_d = mem_q;
        if (|push) mem_d[plr][wr_ptr_q[plr]] = key;
        for (int p = 0; p < 2; p++) begin
            cnt_d[p]    = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
            wr_ptr_d[p] = wr_ptr_q[p] + AW'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + AW'(pop[p]);
        end

        start_d = valid && makeBreak && (inCode == 8'h5A);
        ovf_d   = ovf_q | ovf_set;

        state_d     = state_q;
        ev_player_d = ev_player_q;
        ev_key_d    = ev_key_q;
        last_d      = last_q;
        if (load) begin
            state_d     = PRESENT;
            ev_player_d = gnt;
            ev_key_d    = mem_q[gnt][rd_ptr_q[gnt]];
            last_d      = gnt;
        end else if (accept) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            ev_player_q <= 1'b0;
            ev_key_q    <= 2'd0;
            last_q      <= 1'b1;   // right, so left wins the first tie
            start_q     <= 1'b0;
            ovf_q       <= '0;
            held_q      <= '0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            ev_player_q <= ev_player_d;
            ev_key_q    <= ev_key_d;
            last_q      <= last_d;
            start_q     <= start_d;
            ovf_q       <= ovf_d;
            held_q      <= held_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Storage is not reset; occupancy and pointers define what is live.
    always_ff @(posedge CLOCK_50) begin
        mem_q <= mem_d;
    end

    assign ev_valid    = (state_q == PRESENT);
    assign ev_player   = ev_player_q;
    assign ev_key      = ev_key_q;
    assign held_left   = held_q[0];
    assign held_right  = held_q[1];
    assign start_pulse = start_q;
    assign ovf_left    = ovf_q[0];
    assign ovf_right   = ovf_q[1];
    assign cnt_left    = cnt_q[0];
    assign cnt_right   = cnt_q[1];
endmodule

// File: tb/tb_key_event_scheduler.sv
module tb_key_event_scheduler;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLOCK_50 = 1'b0;
    logic          reset, valid, makeBreak, ev_ready;
    logic [7:0]    inCode;
    logic          ev_valid, ev_player;
    logic [1:0]    ev_key;
    logic [3:0]    held_left, held_right;
    logic          start_pulse, ovf_left, ovf_right;
    logic [CW-1:0] cnt_left, cnt_right;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    key_event_scheduler #(.DEPTH(DEPTH)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .valid(valid), .makeBreak(makeBreak),
        .inCode(inCode), .ev_ready(ev_ready), .ev_valid(ev_valid),
        .ev_player(ev_player), .ev_key(ev_key), .held_left(held_left),
        .held_right(held_right), .start_pulse(start_pulse), .ovf_left(ovf_left),
        .ovf_right(ovf_right), .cnt_left(cnt_left), .cnt_right(cnt_right)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-player queues, one presentation slot, held sets.
    logic [1:0] mq_l[$], mq_r[$];
    bit         m_vld, m_plr, m_last, m_start;
    bit [1:0]   m_key;
    bit [3:0]   m_held[2];
    bit         m_ovf[2];
    logic [2:0] exp_q[$];
    logic [2:0] acc_log[$];

    function automatic bit lookup(input logic [7:0] c, output bit p, output bit [1:0] k);
        p = 0; k = 0; lookup = 1;
        case (c)
            8'h16: k = 0;
            8'h1E: k = 1;
            8'h26: k = 2;
            8'h29: k = 3;
            8'h69: begin p = 1; k = 0; end
            8'h72: begin p = 1; k = 1; end
            8'h7A: begin p = 1; k = 2; end
            8'h59: begin p = 1; k = 3; end
            default: lookup = 0;
        endcase
    endfunction

    task automatic model_step();
        bit acc, p, hit, gnt, ld;
        bit popped[2];
        bit [1:0] k;
        int sz_l, sz_r, sz;
        if (reset) begin
            mq_l.delete(); mq_r.delete(); exp_q.delete();
            m_vld = 0; m_plr = 0; m_key = 0; m_last = 1; m_start = 0;
            m_held[0] = 0; m_held[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
            return;
        end
        acc  = m_vld && ev_ready;
        sz_l = mq_l.size();
        sz_r = mq_r.size();
        popped[0] = 0; popped[1] = 0;
        ld = 0; gnt = 0;
        if (!m_vld || acc) begin
            if (sz_l > 0 && sz_r > 0) begin gnt = !m_last; ld = 1; end
            else if (sz_l > 0)        begin gnt = 0;       ld = 1; end
            else if (sz_r > 0)        begin gnt = 1;       ld = 1; end
        end
        if (ld) begin
            if (gnt) m_key = mq_r.pop_front();
            else     m_key = mq_l.pop_front();
            m_plr = gnt; m_last = gnt; m_vld = 1; popped[gnt] = 1;
            exp_q.push_back({gnt, m_key});
        end else if (acc) begin
            m_vld = 0;
        end
        m_start = valid && makeBreak && (inCode == 8'h5A);
        hit = lookup(inCode, p, k);
        if (valid && hit) begin
            if (!makeBreak) m_held[p][k] = 0;
            else if (!m_held[p][k]) begin
                m_held[p][k] = 1;
                sz = p ? sz_r : sz_l;
                if (sz == DEPTH && !popped[p]) m_ovf[p] = 1;
                else if (p) mq_r.push_back(k);
                else        mq_l.push_back(k);
            end
        end
    endtask

    initial forever begin
        @(posedge CLOCK_50);
        model_step();
    end

    // Monitor: status against the model every cycle, events against the
    // scoreboard queue whenever the DUT hands one over.
    initial forever begin
        logic [2:0] e;
        @(negedge CLOCK_50);
        chk("ev_valid", ev_valid, m_vld);
        chk("held_left", held_left, m_held[0]);
        chk("held_right", held_right, m_held[1]);
        chk("cnt_left", cnt_left, mq_l.size());
        chk("cnt_right", cnt_right, mq_r.size());
        chk("ovf_left", ovf_left, m_ovf[0]);
        chk("ovf_right", ovf_right, m_ovf[1]);
        chk("start_pulse", start_pulse, m_start);
        if (ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_event: got %0d expected none", {ev_player, ev_key});
            end else begin
                e = exp_q.pop_front();
                chk("event", {ev_player, ev_key}, e);
            end
            acc_log.push_back({ev_player, ev_key});
        end
    end

    task automatic drive(input bit v, input bit mb, input logic [7:0] c, input bit rdy);
        valid = v; makeBreak = mb; inCode = c; ev_ready = rdy;
        @(posedge CLOCK_50); #1;
        valid = 0;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) drive(0, 0, 8'h00, rdy);
    endtask

    task automatic release_all();
        logic [7:0] codes[8] = '{8'h16, 8'h1E, 8'h26, 8'h29, 8'h69, 8'h72, 8'h7A, 8'h59};
        for (int i = 0; i < 8; i++) drive(1, 0, codes[i], 1);
    endtask

    initial begin
        logic [7:0] pool[10] = '{8'h16, 8'h1E, 8'h26, 8'h29, 8'h69,
                                 8'h72, 8'h7A, 8'h59, 8'h5A, 8'h1C};
        logic [7:0] c;
        reset = 1; valid = 0; makeBreak = 0; inCode = 0; ev_ready = 0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_held", {held_left, held_right}, 0);
        chk("rst_cnt", {cnt_left, cnt_right}, 0);
        chk("rst_misc", {ev_player, ev_key, start_pulse, ovf_left, ovf_right}, 0);
        reset = 0;

        // single press / release
        acc_log.delete();
        drive(1, 1, 8'h1E, 1);
        chk("sp_held", held_left, 4'b0010);
        chk("sp_latency", ev_valid, 0);
        drive(0, 0, 8'h00, 1);
        chk("sp_valid", ev_valid, 1);
        chk("sp_event", {ev_player, ev_key}, 3'b001);
        drive(1, 0, 8'h1E, 1);
        chk("sp_release", held_left, 4'b0000);
        idle(3, 1);
        chk("sp_count", acc_log.size(), 1);

        // repeat suppression
        acc_log.delete();
        repeat (3) drive(1, 1, 8'h72, 1);
        drive(1, 0, 8'h72, 1);
        idle(4, 1);
        chk("rep_count", acc_log.size(), 1);
        if (acc_log.size() > 0) chk("rep_event", acc_log[0], 3'b101);

        // round robin
        acc_log.delete();
        drive(1, 1, 8'h16, 0);
        drive(1, 1, 8'h26, 0);
        drive(1, 1, 8'h69, 0);
        drive(1, 1, 8'h7A, 0);
        idle(6, 1);
        chk("rr_count", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            chk("rr_0", acc_log[0], 3'b000);
            chk("rr_1", acc_log[1], 3'b100);
            chk("rr_2", acc_log[2], 3'b010);
            chk("rr_3", acc_log[3], 3'b110);
        end
        release_all();
        idle(2, 1);

        // overflow: six queued presses for one player, one in the output
        // register, four in the FIFO, the sixth dropped
        acc_log.delete();
        drive(1, 1, 8'h16, 0);
        drive(1, 1, 8'h1E, 0);
        drive(1, 1, 8'h26, 0);
        drive(1, 1, 8'h29, 0);
        drive(1, 0, 8'h16, 0);
        drive(1, 1, 8'h16, 0);
        chk("ovf_pre", ovf_left, 0);
        drive(1, 0, 8'h16, 0);
        drive(1, 1, 8'h16, 0);
        chk("ovf_cnt", cnt_left, DEPTH);
        chk("ovf_flag", ovf_left, 1);
        chk("ovf_held", held_left, 4'b1111);
        idle(10, 1);
        chk("ovf_delivered", acc_log.size(), 5);
        chk("ovf_sticky", ovf_left, 1);
        release_all();

        // Enter and unmapped code
        drive(1, 1, 8'h5A, 1);
        chk("ent_pulse", start_pulse, 1);
        chk("ent_cnt", cnt_left + cnt_right, 0);
        drive(0, 0, 8'h00, 1);
        chk("ent_pulse_end", start_pulse, 0);
        drive(1, 1, 8'h5A, 1);
        chk("ent_repeat", start_pulse, 1);
        drive(1, 1, 8'h1C, 1);
        chk("unmapped", {start_pulse, ev_valid, held_left, held_right}, 0);

        // random traffic
        repeat (400) begin
            c = pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) c = 8'($urandom);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, c,
                  $urandom_range(0, 3) != 0);
        end
        idle(20, 1);
        chk("rand_drained", exp_q.size(), 0);

        // reset while presenting with queues non-empty
        release_all();
        idle(2, 1);
        drive(1, 1, 8'h16, 0);
        drive(1, 1, 8'h69, 0);
        drive(1, 1, 8'h1E, 0);
        chk("mid_valid", ev_valid, 1);
        chk("mid_queued", (cnt_left + cnt_right) > 0, 1);
        reset = 1;
        drive(1, 1, 8'h26, 0);
        chk("mr_valid", ev_valid, 0);
        chk("mr_out", {ev_player, ev_key}, 0);
        chk("mr_held", {held_left, held_right}, 0);
        chk("mr_cnt", {cnt_left, cnt_right}, 0);
        chk("mr_misc", {start_pulse, ovf_left, ovf_right}, 0);
        reset = 0;
        idle(3, 1);
        chk("mr_after", ev_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
